seven_seg_scan: RTL and testbench

//  Parametrised multiplexed 7-segment driver for player health/score readouts.

---
 rtl/seven_seg_scan.sv | 147 ++++++++++++++
 tb/tb_seven_seg_scan.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan
//   Multiplexed common-anode 7-segment driver. Scans NUM_DIGITS digits, one per
//   REFRESH_DIV-cycle slot, with hex decode, per-digit enable, decimal point,
//   frame-based blink and DEAD_CYCLES of all-anodes-off at each slot start.
// Ports
//   clk        : system clock, all logic on posedge
//   rst        : synchronous active-high reset
//   digits     : hex nibble per digit, digit i = digits[4i+3:4i]
//   digit_en   : 1 = digit displayed, 0 = blanked
//   dp         : 1 = decimal point lit on that digit
//   blink      : 1 = digit blanked during the blink-off phase
//   seg        : active-low {dp,g,f,e,d,c,b,a}, registered
//   an         : active-low anodes, an[0] = rightmost digit, registered
//   frame_tick : one-cycle pulse after the last slot of each scan frame
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  ft_q, ft_d;

  logic                  cnt_end, frame_end, live, vis;
  logic [3:0]            nib;
  logic                  en_sel, dp_sel, bl_sel;

  // gfedcba, active low
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      default: dec = 7'b0001110;
    endcase
  endfunction

  // With no dead time the anode is live for the whole slot; splitting this
  // out avoids an always-true unsigned compare against zero.
  if (DEAD_CYCLES == 0) begin : g_nodead
    assign live = 1'b1;
  end else begin : g_dead
    assign live = (cnt_q >= CW'(DEAD_CYCLES));
  end

  always_comb begin
    cnt_end   = (cnt_q == CW'(REFRESH_DIV - 1));
    frame_end = cnt_end && (idx_q == IW'(NUM_DIGITS - 1));

    cnt_d = cnt_end ? '0 : cnt_q + 1'b1;

    // Explicit wrap at NUM_DIGITS-1 so non-power-of-2 counts never overrun.
    idx_d = idx_q;
    if (cnt_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    nib    = '0;
    en_sel = 1'b0;
    dp_sel = 1'b0;
    bl_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = digits[4*i +: 4];
        en_sel = digit_en[i];
        dp_sel = dp[i];
        bl_sel = blink[i];
      end
    end

    vis = en_sel & ~(bl_sel & phase_q);

    an_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (vis && live && (idx_q == IW'(i))) an_d[i] = 1'b0;
    end

    seg_d = vis ? {~dp_sel, dec(nib)} : 8'hFF;
    ft_d  = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      ft_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ft_q    <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] digits;
  logic [3:0]  digit_en, dp, blink;

  logic [7:0]  seg_a, seg_b;
  logic [3:0]  an_a;
  logic [2:0]  an_b;
  logic        ft_a, ft_b;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;   // cycles since reset release, state before next edge

  seven_seg_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .digits(digits), .digit_en(digit_en), .dp(dp),
    .blink(blink), .seg(seg_a), .an(an_a), .frame_tick(ft_a)
  );

  seven_seg_scan #(
    .NUM_DIGITS(3), .REFRESH_DIV(2), .DEAD_CYCLES(0), .BLINK_FRAMES(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .digits(digits[11:0]), .digit_en(digit_en[2:0]),
    .dp(dp[2:0]), .blink(blink[2:0]), .seg(seg_b), .an(an_b), .frame_tick(ft_b)
  );

  logic [6:0] dec_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, act, exp, t, $time);
    end
  endtask

  // Outputs after the next edge, from elapsed cycles since reset and inputs now.
  function automatic void model(input int nd, input int rd, input int dc, input int bf,
                                input int tt, input logic [15:0] dg, input logic [3:0] en,
                                input logic [3:0] dpv, input logic [3:0] bl,
                                output logic [7:0] s, output logic [7:0] a, output logic f);
    int cnt, idx, frame, ph;
    logic vis;
    cnt   = tt % rd;
    idx   = (tt / rd) % nd;
    frame = tt / (rd * nd);
    ph    = (frame / bf) % 2;
    vis   = en[idx] && !(bl[idx] && ph == 1);
    a = 8'hFF;
    if (vis && cnt >= dc) a[idx] = 1'b0;
    s = vis ? {~dpv[idx], dec_tbl[dg[idx*4 +: 4]]} : 8'hFF;
    f = ((tt % (rd * nd)) == rd * nd - 1);
  endfunction

  task automatic cycle();
    logic [7:0] sa, aa, sb, ab;
    logic       fa, fb;
    if (rst) begin
      sa = 8'hFF; aa = 8'hFF; fa = 1'b0;
      sb = 8'hFF; ab = 8'hFF; fb = 1'b0;
    end else begin
      model(4, 4, 1, 2, t, digits, digit_en, dp, blink, sa, aa, fa);
      model(3, 2, 0, 1, t, digits, digit_en, dp, blink, sb, ab, fb);
    end
    @(posedge clk);
    #1;
    check_eq("A_seg", seg_a, sa);
    check_eq("A_an",  an_a,  aa[3:0]);
    check_eq("A_ft",  ft_a,  fa);
    check_eq("B_seg", seg_b, sb);
    check_eq("B_an",  an_b,  ab[2:0]);
    check_eq("B_ft",  ft_b,  fb);
    t = rst ? 0 : t + 1;
  endtask

  initial begin
    // reset held with live inputs
    rst      = 1'b1;
    digits   = 16'($urandom);
    digit_en = 4'hF;
    dp       = 4'($urandom);
    blink    = 4'($urandom);
    repeat (3) cycle();

    // plain scan of 4321
    rst      = 1'b0;
    digits   = 16'h4321;
    digit_en = 4'hF;
    dp       = 4'h0;
    blink    = 4'h0;
    repeat (32) cycle();

    // enable and decimal point
    digit_en = 4'b1010;
    dp       = 4'b0010;
    repeat (16) cycle();

    // blink on digit 0 across several half-periods
    digits   = 16'h000F;
    digit_en = 4'hF;
    dp       = 4'h0;
    blink    = 4'b0001;
    repeat (128) cycle();

    // reset mid-slot during blink-off: cnt=2, idx=2, phase=1 is t=42
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (42) cycle();
    check_eq("T_pos", t, 42);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (40) cycle();

    // randomized inputs with occasional reset
    repeat (800) begin
      digits   = 16'($urandom);
      digit_en = 4'($urandom);
      dp       = 4'($urandom);
      blink    = 4'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    repeat (8) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
